// File: rtl/sky_cycle_if.sv
// Control inputs and sky-state outputs shared by the day/night sequencer
// and its consumers.
interface sky_cycle_if;
  logic        frame;
  logic        pause;
  logic        force_night;
  logic [15:0] frame_count;
  logic [7:0]  fade_level;
  logic [1:0]  phase;
  logic        phase_change;

  modport master (
    output frame, pause, force_night,
    input  frame_count, fade_level, phase, phase_change
  );

  modport slave (
    input  frame, pause, force_night,
    output frame_count, fade_level, phase, phase_change
  );
endinterface

// File: rtl/sky_cycle_ctrl.sv
// Day/night sequencer: counts frames and runs DAY -> DUSK -> NIGHT -> DAWN,
// producing the fade level used by the star overlay and sky colour stages.
module sky_cycle_ctrl #(
  parameter int unsigned DAY_FRAMES   = 240,
  parameter int unsigned NIGHT_FRAMES = 240,
  parameter int unsigned STEP         = 4,
  parameter int unsigned STEP_DIV     = 2
) (
  input  logic         clk_pix,
  input  logic         rst_n,
  sky_cycle_if.slave   bus
);

  localparam int unsigned HOLD_W = 16;
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned FADE_W = 8;

  localparam logic [HOLD_W-1:0] DAY_LAST   = HOLD_W'(DAY_FRAMES - 1);
  localparam logic [HOLD_W-1:0] NIGHT_LAST = HOLD_W'(NIGHT_FRAMES - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(STEP_DIV - 1);
  localparam logic [FADE_W-1:0] STEP_B     = FADE_W'(STEP);
  localparam logic [FADE_W-1:0] FADE_MAX   = FADE_W'(255);

  typedef enum logic [1:0] {
    PH_DAY   = 2'd0,
    PH_DUSK  = 2'd1,
    PH_NIGHT = 2'd2,
    PH_DAWN  = 2'd3
  } phase_e;

  phase_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [FADE_W-1:0]   fade_q, fade_d;
  logic [15:0]         fcnt_q, fcnt_d;
  logic                pc_q, pc_d;
  logic [FADE_W:0]     ramp_up;

  // State register
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PH_DAY;
      hold_q  <= '0;
      div_q   <= '0;
      fade_q  <= FADE_MAX;
      fcnt_q  <= '0;
      pc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      div_q   <= div_d;
      fade_q  <= fade_d;
      fcnt_q  <= fcnt_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state: force_night beats pause; frame_count ignores both
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    div_d   = div_q;
    fade_d  = fade_q;
    fcnt_d  = fcnt_q;
    pc_d    = 1'b0;
    ramp_up = {1'b0, fade_q} + {1'b0, STEP_B};

    if (bus.frame) fcnt_d = fcnt_q + 16'd1;

    if (bus.force_night) begin
      state_d = PH_NIGHT;
      fade_d  = '0;
      hold_d  = '0;
      div_d   = '0;
      pc_d    = (state_q != PH_NIGHT);
    end else if (bus.frame && !bus.pause) begin
      case (state_q)
        PH_DAY: begin
          if (hold_q == DAY_LAST) begin
            state_d = PH_DUSK;
            hold_d  = '0;
            div_d   = '0;
            pc_d    = 1'b1;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        PH_DUSK: begin
          if (div_q == DIV_LAST) begin
            div_d  = '0;
            fade_d = (fade_q <= STEP_B) ? '0 : fade_q - STEP_B;
            if (fade_d == '0) begin
              state_d = PH_NIGHT;
              hold_d  = '0;
              pc_d    = 1'b1;
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        PH_NIGHT: begin
          if (hold_q == NIGHT_LAST) begin
            state_d = PH_DAWN;
            hold_d  = '0;
            div_d   = '0;
            pc_d    = 1'b1;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        PH_DAWN: begin
          if (div_q == DIV_LAST) begin
            div_d  = '0;
            fade_d = (ramp_up >= {1'b0, FADE_MAX}) ? FADE_MAX : ramp_up[FADE_W-1:0];
            if (fade_d == FADE_MAX) begin
              state_d = PH_DAY;
              hold_d  = '0;
              pc_d    = 1'b1;
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.frame_count  = fcnt_q;
  assign bus.fade_level   = fade_q;
  assign bus.phase        = state_q;
  assign bus.phase_change = pc_q;

endmodule

// File: tb/tb_sky_cycle_ctrl.sv
// Directed bench for sky_cycle_ctrl: default, small-ramp and saturating
// parameter sets driven from one shared clock and reset.
module tb_sky_cycle_ctrl;

  logic clk_pix = 1'b0;
  logic rst_n   = 1'b0;
  int   n_cmp   = 0;
  int   n_bad   = 0;

  always #5 clk_pix = ~clk_pix;

  sky_cycle_if if_d ();
  sky_cycle_if if_s ();
  sky_cycle_if if_t ();

  sky_cycle_ctrl u_d (.clk_pix(clk_pix), .rst_n(rst_n), .bus(if_d));

  sky_cycle_ctrl #(.DAY_FRAMES(4), .NIGHT_FRAMES(3), .STEP(64), .STEP_DIV(2))
    u_s (.clk_pix(clk_pix), .rst_n(rst_n), .bus(if_s));

  sky_cycle_ctrl #(.DAY_FRAMES(2), .NIGHT_FRAMES(2), .STEP(255), .STEP_DIV(1))
    u_t (.clk_pix(clk_pix), .rst_n(rst_n), .bus(if_t));

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic frames_d(input int n);
    if_d.frame = 1'b1;
    for (int i = 0; i < n; i++) tick();
    if_d.frame = 1'b0;
  endtask

  task automatic test_reset();
    frames_d(5);
    rst_n = 1'b0;
    #2;
    n_cmp++; if (if_d.frame_count !== 16'd0) begin n_bad++; $display("FAIL rst_fc got %0d want 0", if_d.frame_count); end
    n_cmp++; if (if_d.fade_level !== 8'd255) begin n_bad++; $display("FAIL rst_fade got %0d want 255", if_d.fade_level); end
    n_cmp++; if (if_d.phase !== 2'd0) begin n_bad++; $display("FAIL rst_phase got %0d want 0", if_d.phase); end
    n_cmp++; if (if_d.phase_change !== 1'b0) begin n_bad++; $display("FAIL rst_pc got %0d want 0", if_d.phase_change); end
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      frames_d(1);
      tick();
    end
    n_cmp++; if (if_d.frame_count !== 16'd3) begin n_bad++; $display("FAIL cnt3_fc got %0d want 3", if_d.frame_count); end
    n_cmp++; if (if_d.fade_level !== 8'd255) begin n_bad++; $display("FAIL cnt3_fade got %0d want 255", if_d.fade_level); end
    n_cmp++; if (if_d.phase !== 2'd0) begin n_bad++; $display("FAIL cnt3_phase got %0d want 0", if_d.phase); end
  endtask

  // Continues from test_reset: hold=3, frame_count=3
  task automatic test_pause();
    frames_d(237);
    n_cmp++; if (if_d.phase !== 2'd1) begin n_bad++; $display("FAIL dusk_entry got %0d want 1", if_d.phase); end
    frames_d(20);
    n_cmp++; if (if_d.fade_level !== 8'd215) begin n_bad++; $display("FAIL dusk_fade got %0d want 215", if_d.fade_level); end
    if_d.pause = 1'b1;
    if_d.frame = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (if_d.phase_change !== 1'b0) begin n_bad++; $display("FAIL pause_pc[%0d] got %0d want 0", i, if_d.phase_change); end
    end
    if_d.frame = 1'b0;
    n_cmp++; if (if_d.fade_level !== 8'd215) begin n_bad++; $display("FAIL pause_fade got %0d want 215", if_d.fade_level); end
    n_cmp++; if (if_d.phase !== 2'd1) begin n_bad++; $display("FAIL pause_phase got %0d want 1", if_d.phase); end
    n_cmp++; if (if_d.frame_count !== 16'd270) begin n_bad++; $display("FAIL pause_fc got %0d want 270", if_d.frame_count); end
    if_d.pause = 1'b0;
    frames_d(2);
    n_cmp++; if (if_d.fade_level !== 8'd211) begin n_bad++; $display("FAIL resume_fade got %0d want 211", if_d.fade_level); end
  endtask

  task automatic test_full_cycle();
    int eph [24];
    int efd [24];
    int epc [24];
    eph = '{0,0,0,1,1,1,1,1,1,1,1,2,2,2,3,3,3,3,3,3,3,3,0,0};
    efd = '{255,255,255,255,255,191,191,127,127,63,63,0,0,0,0,0,64,64,128,128,192,192,255,255};
    epc = '{0,0,0,1,0,0,0,0,0,0,0,1,0,0,1,0,0,0,0,0,0,0,1,0};
    do_reset();
    if_s.frame = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      n_cmp++; if (int'(if_s.phase) !== eph[i]) begin n_bad++; $display("FAIL cyc_phase f%0d got %0d want %0d", i+1, if_s.phase, eph[i]); end
      n_cmp++; if (int'(if_s.fade_level) !== efd[i]) begin n_bad++; $display("FAIL cyc_fade f%0d got %0d want %0d", i+1, if_s.fade_level, efd[i]); end
      n_cmp++; if (int'(if_s.phase_change) !== epc[i]) begin n_bad++; $display("FAIL cyc_pc f%0d got %0d want %0d", i+1, if_s.phase_change, epc[i]); end
    end
    if_s.frame = 1'b0;
  endtask

  task automatic test_force_night();
    do_reset();
    frames_d(10);
    if_d.pause       = 1'b1;
    if_d.force_night = 1'b1;
    if_d.frame       = 1'b1;
    tick();
    if_d.pause = 1'b0;
    n_cmp++; if (if_d.fade_level !== 8'd0) begin n_bad++; $display("FAIL fn_fade got %0d want 0", if_d.fade_level); end
    n_cmp++; if (if_d.phase !== 2'd2) begin n_bad++; $display("FAIL fn_phase got %0d want 2", if_d.phase); end
    n_cmp++; if (if_d.phase_change !== 1'b1) begin n_bad++; $display("FAIL fn_pc got %0d want 1", if_d.phase_change); end
    n_cmp++; if (if_d.frame_count !== 16'd11) begin n_bad++; $display("FAIL fn_fc got %0d want 11", if_d.frame_count); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (if_d.phase_change !== 1'b0) begin n_bad++; $display("FAIL fn_held_pc[%0d] got %0d want 0", i, if_d.phase_change); end
      n_cmp++; if (if_d.phase !== 2'd2) begin n_bad++; $display("FAIL fn_held_phase[%0d] got %0d want 2", i, if_d.phase); end
    end
    if_d.force_night = 1'b0;
    n_cmp++; if (if_d.frame_count !== 16'd16) begin n_bad++; $display("FAIL fn_held_fc got %0d want 16", if_d.frame_count); end
    frames_d(239);
    n_cmp++; if (if_d.phase !== 2'd2) begin n_bad++; $display("FAIL fn_night_hold got %0d want 2", if_d.phase); end
    frames_d(1);
    n_cmp++; if (if_d.phase !== 2'd3) begin n_bad++; $display("FAIL fn_dawn got %0d want 3", if_d.phase); end
    n_cmp++; if (if_d.phase_change !== 1'b1) begin n_bad++; $display("FAIL fn_dawn_pc got %0d want 1", if_d.phase_change); end
  endtask

  task automatic test_saturation();
    int eph [7];
    int efd [7];
    int epc [7];
    eph = '{0,1,2,2,3,0,0};
    efd = '{255,255,0,0,0,255,255};
    epc = '{0,1,1,0,1,1,0};
    do_reset();
    if_t.frame = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_cmp++; if (int'(if_t.phase) !== eph[i]) begin n_bad++; $display("FAIL sat_phase f%0d got %0d want %0d", i+1, if_t.phase, eph[i]); end
      n_cmp++; if (int'(if_t.fade_level) !== efd[i]) begin n_bad++; $display("FAIL sat_fade f%0d got %0d want %0d", i+1, if_t.fade_level, efd[i]); end
      n_cmp++; if (int'(if_t.phase_change) !== epc[i]) begin n_bad++; $display("FAIL sat_pc f%0d got %0d want %0d", i+1, if_t.phase_change, epc[i]); end
    end
    if_t.frame = 1'b0;
  endtask

  // 65535 frames lands 31 frames into a DAY hold (cycle length 736)
  task automatic test_wrap();
    do_reset();
    frames_d(65535);
    n_cmp++; if (if_d.frame_count !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_pre_fc got %h want ffff", if_d.frame_count); end
    n_cmp++; if (if_d.fade_level !== 8'd255) begin n_bad++; $display("FAIL wrap_pre_fade got %0d want 255", if_d.fade_level); end
    frames_d(1);
    n_cmp++; if (if_d.frame_count !== 16'h0000) begin n_bad++; $display("FAIL wrap_fc got %h want 0000", if_d.frame_count); end
    n_cmp++; if (if_d.fade_level !== 8'd255) begin n_bad++; $display("FAIL wrap_fade got %0d want 255", if_d.fade_level); end
    n_cmp++; if (if_d.phase !== 2'd0) begin n_bad++; $display("FAIL wrap_phase got %0d want 0", if_d.phase); end
    n_cmp++; if (if_d.phase_change !== 1'b0) begin n_bad++; $display("FAIL wrap_pc got %0d want 0", if_d.phase_change); end
  endtask

  initial begin
    if_d.frame = 1'b0; if_d.pause = 1'b0; if_d.force_night = 1'b0;
    if_s.frame = 1'b0; if_s.pause = 1'b0; if_s.force_night = 1'b0;
    if_t.frame = 1'b0; if_t.pause = 1'b0; if_t.force_night = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();
    test_reset();
    test_pause();
    test_full_cycle();
    test_force_night();
    test_saturation();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
